uart_tx_port: RTL and testbench

Memory-mapped UART transmitter that responds to CPU bus accesses: the CPU writes bytes into a 4-entry FIFO, and the block serialises them on `tx` as 8N1 frames. It sits on the shared 8-bit data bus next to the RAM and LED peripherals, selected by an external address decode into `cs`. The CPU polls a status register; there is no interrupt.

---
 rtl/uart_tx_port_if.sv | 11 +
 rtl/uart_tx_port.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_port.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_port_if.sv
// CPU-side register access strobes for the UART transmitter.
// The tri-state data bus stays a separate inout net on the peripheral.
interface uart_tx_port_if;
  logic [1:0] address;
  logic       cs;
  logic       write;
  logic       read;

  modport master (output address, cs, write, read);
  modport slave  (input  address, cs, write, read);
endinterface

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: 4-entry byte FIFO, programmable divisor,
// status polling over a shared tri-state data bus.
module uart_tx_port #(
  parameter logic [7:0] DIV_RESET = 8'd3
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_port_if.slave        bus,
  inout  wire  [7:0]           data_bus,
  output logic                 tx
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  bit_cnt_q;
  logic [7:0]  frame_div_q;
  logic        tx_q;

  logic [7:0]  mem_q [4];
  logic [1:0]  wptr_q;
  logic [1:0]  rptr_q;
  logic [2:0]  count_q;
  logic        overrun_q;
  logic [7:0]  div_q;
  logic        wr_prev_q;

  logic        wr_fire;
  logic        push;
  logic        push_ok;
  logic        pop;
  logic        busy;
  logic        rd_en;
  logic [7:0]  rdata;
  logic [7:0]  head;

  // One action per write strobe assertion, however long it is held.
  assign wr_fire = bus.cs && bus.write && !wr_prev_q;
  assign push    = wr_fire && (bus.address == 2'd0);
  assign head    = mem_q[rptr_q];

  // Pops only look at the registered count, so a same-edge push never feeds a pop.
  assign pop = (count_q != 3'd0) &&
               ((state_q == S_IDLE) || ((state_q == S_STOP) && (bit_cnt_q == 8'd0)));
  assign push_ok = push && ((count_q != 3'd4) || pop);
  assign busy    = (state_q != S_IDLE) || (count_q != 3'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_prev_q <= 1'b0;
      wptr_q    <= 2'd0;
      rptr_q    <= 2'd0;
      count_q   <= 3'd0;
      overrun_q <= 1'b0;
      div_q     <= DIV_RESET;
      for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
    end else begin
      wr_prev_q <= bus.cs && bus.write;
      if (push_ok) begin
        mem_q[wptr_q] <= data_bus;
        wptr_q        <= wptr_q + 2'd1;
      end
      if (pop) rptr_q <= rptr_q + 2'd1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
      if (push && !push_ok)
        overrun_q <= 1'b1;
      else if (wr_fire && (bus.address == 2'd1) && data_bus[3])
        overrun_q <= 1'b0;
      if (wr_fire && (bus.address == 2'd2)) div_q <= data_bus;
    end
  end

  // The divisor is captured per frame so DIV writes only affect the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      shift_q     <= 8'h00;
      bit_idx_q   <= 3'd0;
      bit_cnt_q   <= 8'd0;
      frame_div_q <= 8'd0;
      tx_q        <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q     <= head;
            frame_div_q <= div_q;
            bit_cnt_q   <= div_q;
            tx_q        <= 1'b0;
            state_q     <= S_START;
          end
        end
        S_START: begin
          if (bit_cnt_q == 8'd0) begin
            bit_idx_q <= 3'd0;
            bit_cnt_q <= frame_div_q;
            tx_q      <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            bit_cnt_q <= bit_cnt_q - 8'd1;
          end
        end
        S_DATA: begin
          if (bit_cnt_q == 8'd0) begin
            bit_cnt_q <= frame_div_q;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 8'd1;
          end
        end
        S_STOP: begin
          if (bit_cnt_q == 8'd0) begin
            if (pop) begin
              shift_q     <= head;
              frame_div_q <= div_q;
              bit_cnt_q   <= div_q;
              tx_q        <= 1'b0;
              state_q     <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 8'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_en = bus.cs && bus.read && !bus.write;

  always_comb begin
    rdata = 8'h00;
    case (bus.address)
      2'd1:    rdata = {4'b0000, overrun_q, (count_q == 3'd0), (count_q == 3'd4), busy};
      2'd2:    rdata = div_q;
      2'd3:    rdata = {5'b00000, count_q};
      default: rdata = 8'h00;
    endcase
  end

  assign data_bus = rd_en ? rdata : 8'hzz;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: directed CPU accesses, expected frames queued at stimulus
// time and checked by an independent serial-line monitor.
module tb_uart_tx_port;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_port_if bus_if ();
  wire  [7:0] data_bus;
  logic       cpu_oe = 1'b0;
  logic [7:0] cpu_d  = 8'h00;
  logic       tx;

  assign data_bus = cpu_oe ? cpu_d : 8'hzz;

  uart_tx_port #(.DIV_RESET(8'd3)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if.slave),
    .data_bus (data_bus),
    .tx       (tx)
  );

  typedef struct {
    logic [7:0] data;
    int         per;
  } exp_t;

  exp_t exp_q[$];
  int   start_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wr_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Serial monitor: decodes each frame at the expected bit period, sample by sample.
  initial begin : monitor
    exp_t       e;
    logic [9:0] frame;
    logic [7:0] got;
    logic       ok;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (reset && !tx) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame start at cycle %0d, no frame expected", cyc);
        end else begin
          e = exp_q.pop_front();
          start_q.push_back(cyc);
          frame   = {1'b1, e.data, 1'b0};
          ok      = 1'b1;
          aborted = 1'b0;
          got     = 8'h00;
          for (int s = 0; s < 10 * e.per; s++) begin
            if (s > 0) @(negedge clk);
            if (!reset) begin
              aborted = 1'b1;
              break;
            end
            if (tx !== frame[s / e.per]) ok = 1'b0;
            if ((s / e.per >= 1) && (s / e.per <= 8) && (s % e.per == e.per / 2))
              got[s / e.per - 1] = tx;
          end
          if (!aborted) begin
            checks++;
            if (!ok) begin
              errors++;
              $display("FAIL frame byte got %h exp %h (bit period %0d, timing or level wrong)",
                       got, e.data, e.per);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    bus_if.address = a;
    bus_if.cs      = 1'b1;
    bus_if.read    = 1'b1;
    #1;
    v = data_bus;
    bus_if.cs   = 1'b0;
    bus_if.read = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [7:0] exp, input string name);
    logic [7:0] v;
    rd(a, v);
    chk(name, int'(v), int'(exp));
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus_if.address = a;
    bus_if.cs      = 1'b1;
    bus_if.write   = 1'b1;
    cpu_oe         = 1'b1;
    cpu_d          = d;
    @(posedge clk); #1;
    wr_edge      = cyc;
    bus_if.cs    = 1'b0;
    bus_if.write = 1'b0;
    cpu_oe       = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input int maxc, input string name);
    logic [7:0] s;
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      rd(2'd1, s);
      n++;
    end while (s[0] && n < maxc);
    if (s[0]) begin
      checks++;
      errors++;
      $display("FAIL %s still busy after %0d cycles, status %h", name, n, s);
    end
  endtask

  task automatic chk_gaps(input int n, input int per, input int first, input string name);
    chk({name, "_nframes"}, start_q.size(), n);
    if (start_q.size() == n) begin
      chk({name, "_first_start"}, start_q[0], first);
      for (int i = 1; i < n; i++)
        chk({name, "_frame_spacing"}, start_q[i] - start_q[i-1], 10 * per);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int e0;
    int lows;
    bus_if.address = 2'd0;
    bus_if.cs      = 1'b0;
    bus_if.write   = 1'b0;
    bus_if.read    = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Reset defaults
    chk("reset_tx", int'(tx), 1);
    rd_chk(2'd1, 8'h04, "reset_status");
    rd_chk(2'd2, 8'h03, "reset_div");
    rd_chk(2'd3, 8'h00, "reset_count");
    rd_chk(2'd0, 8'h00, "read_addr0");

    // Single frame, div=3
    start_q.delete();
    exp_q.push_back('{8'hA5, 4});
    wr(2'd0, 8'hA5);
    e0 = wr_edge;
    wait_cyc(e0 + 40);
    rd_chk(2'd1, 8'h05, "busy_at_clock40");
    wait_cyc(e0 + 41);
    rd_chk(2'd1, 8'h04, "busy_clear");
    chk_gaps(1, 4, e0 + 1, "single");

    // FIFO fill and overrun
    start_q.delete();
    for (int i = 1; i <= 5; i++) exp_q.push_back('{8'(i), 4});
    wr(2'd0, 8'h01);
    e0 = wr_edge;
    wr(2'd0, 8'h02);
    wr(2'd0, 8'h03);
    wr(2'd0, 8'h04);
    wr(2'd0, 8'h05);
    wr(2'd0, 8'h06);
    rd_chk(2'd1, 8'h0B, "status_overrun_full");
    rd_chk(2'd3, 8'h04, "count_peak");
    wr(2'd1, 8'h08);
    rd_chk(2'd1, 8'h03, "overrun_clear");
    wait_idle(1000, "fifo_drain");
    chk_gaps(5, 4, e0 + 1, "fifo");

    // Divisor change mid-frame
    start_q.delete();
    wr(2'd2, 8'h01);
    exp_q.push_back('{8'hFF, 2});
    exp_q.push_back('{8'h00, 8});
    wr(2'd0, 8'hFF);
    e0 = wr_edge;
    wr(2'd0, 8'h00);
    wr(2'd2, 8'h07);
    rd_chk(2'd2, 8'h07, "div_readback");
    wait_idle(1000, "div_drain");
    chk_gaps(2, 2, e0 + 1, "divchg");

    // Strobe hold, then reset mid-frame
    wr(2'd2, 8'h03);
    exp_q.push_back('{8'h55, 4});
    exp_q.push_back('{8'h3C, 4});
    wr(2'd0, 8'h55);
    e0 = wr_edge;
    bus_if.address = 2'd0;
    bus_if.cs      = 1'b1;
    bus_if.write   = 1'b1;
    cpu_oe         = 1'b1;
    cpu_d          = 8'h3C;
    repeat (5) @(posedge clk);
    #1;
    bus_if.cs    = 1'b0;
    bus_if.write = 1'b0;
    cpu_oe       = 1'b0;
    rd_chk(2'd3, 8'h01, "count_strobe_hold");
    wr(2'd2, 8'h09);
    wait_cyc(e0 + 14);
    reset = 1'b0;
    #1;
    chk("tx_async_reset", int'(tx), 1);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    rd_chk(2'd3, 8'h00, "count_after_reset");
    rd_chk(2'd1, 8'h04, "status_after_reset");
    rd_chk(2'd2, 8'h03, "div_after_reset");
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("idle_after_reset_low_samples", lows, 0);

    chk("frames_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
